pop_cycle_monitor: RTL and testbench

POP_CYCLE_MONITOR -- requirements
Module: pop_cycle_monitor

---
 rtl/pop_cycle_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_pop_cycle_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_cycle_monitor.sv
// Pump/MW/probe timing monitor for one POP cycle. It synchronises the observed signals,
// tracks the expected pulse order and reports the widths, the cycle period and any sequence error.
module pop_cycle_monitor #(
   parameter int W           = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_2M5,
   input  logic         reset,
   input  logic         pump,
   input  logic         probe,
   input  logic         MW,
   input  logic         sample,
   input  logic         clear_error,
   output logic [W-1:0] pump_width,
   output logic [W-1:0] mw1_width,
   output logic [W-1:0] free_precess,
   output logic [W-1:0] mw2_width,
   output logic [W-1:0] probe_width,
   output logic         meas_valid,
   output logic [W-1:0] cycle_period,
   output logic         period_valid,
   output logic [W-1:0] good_cycles,
   output logic         seq_error,
   output logic [1:0]   error_code
);

   typedef enum logic [2:0] {IDLE, PUMP, GAP, MW1, FREE, MW2, WAITP, PROBE} state_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_EDGE, ERR_TIMEOUT, ERR_SAMPLE} err_t;

   localparam logic [W-1:0] CNT_MAX = '1;

   // Bit order in every synchroniser stage: {sample, probe, MW, pump}.
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0]                  sync_s;
   logic [2:0]                  prev_q, rise, fall;

   state_t        state_q, state_d;
   err_t          code_q, code_d, err_kind;
   logic          enter, err_hit, bad_now;
   logic          seen_q, seen_d, bad_q, bad_d, seq_error_q, seq_error_d;
   logic          meas_valid_q, meas_valid_d, period_valid_q, period_valid_d;
   logic [W-1:0]  dur_q, dur_d, period_q, period_d;
   logic [W-1:0]  pump_h_q, pump_h_d, mw1_h_q, mw1_h_d, free_h_q, free_h_d, mw2_h_q, mw2_h_d;
   logic [W-1:0]  pump_w_q, pump_w_d, mw1_w_q, mw1_w_d, free_w_q, free_w_d;
   logic [W-1:0]  mw2_w_q, mw2_w_d, probe_w_q, probe_w_d;
   logic [W-1:0]  cycle_period_q, cycle_period_d, good_q, good_d;

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign rise   = sync_s[2:0] & ~prev_q;
   assign fall   = ~sync_s[2:0] & prev_q;

   always_ff @(posedge clk_2M5) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the value from before the edge.
         sync_q <= {sync_q[SYNC_STAGES-2:0], {sample, probe, MW, pump}};
         prev_q <= sync_s[2:0];
      end
   end

   always_comb begin
      // NOTE: every signal gets its default first, so no path through the chain below infers a latch.
      state_d        = state_q;
      enter          = 1'b0;
      err_hit        = 1'b0;
      err_kind       = ERR_NONE;
      dur_d          = (dur_q == CNT_MAX) ? dur_q : dur_q + 1'b1;
      period_d       = (period_q == CNT_MAX) ? period_q : period_q + 1'b1;
      bad_now        = bad_q | ~sync_s[3];
      bad_d          = (state_q == PROBE) ? bad_now : bad_q;
      seen_d         = seen_q;
      pump_h_d       = pump_h_q;
      mw1_h_d        = mw1_h_q;
      free_h_d       = free_h_q;
      mw2_h_d        = mw2_h_q;
      pump_w_d       = pump_w_q;
      mw1_w_d        = mw1_w_q;
      free_w_d       = free_w_q;
      mw2_w_d        = mw2_w_q;
      probe_w_d      = probe_w_q;
      meas_valid_d   = 1'b0;
      good_d         = good_q;
      cycle_period_d = cycle_period_q;
      period_valid_d = 1'b0;
      seq_error_d    = seq_error_q;
      code_d         = code_q;

      // A saturated period counter means the interval overflowed and is not reported.
      if (rise[0]) begin
         period_d = W'(1);
         seen_d   = 1'b1;
         if (seen_q && period_q != CNT_MAX) begin
            cycle_period_d = period_q;
            period_valid_d = 1'b1;
         end
      end

      if (rise[0]) begin
         if (state_q != IDLE) begin
            err_hit  = 1'b1;
            err_kind = ERR_EDGE;
         end
         state_d = PUMP;
         enter   = 1'b1;
      end else if (fall[0] && state_q == PUMP) begin
         pump_h_d = dur_q;
         state_d  = GAP;
         enter    = 1'b1;
      end else if (rise[1]) begin
         enter = 1'b1;
         if (state_q == GAP) begin
            state_d = MW1;
         end else if (state_q == FREE) begin
            free_h_d = dur_q;
            state_d  = MW2;
         end else begin
            err_hit  = 1'b1;
            err_kind = ERR_EDGE;
            state_d  = IDLE;
         end
      end else if (fall[1] && (state_q == MW1 || state_q == MW2)) begin
         enter = 1'b1;
         if (state_q == MW1) begin
            mw1_h_d = dur_q;
            state_d = FREE;
         end else begin
            mw2_h_d = dur_q;
            state_d = WAITP;
         end
      end else if (rise[2]) begin
         enter = 1'b1;
         if (state_q == WAITP) begin
            state_d = PROBE;
         end else begin
            err_hit  = 1'b1;
            err_kind = ERR_EDGE;
            state_d  = IDLE;
         end
      end else if (fall[2] && state_q == PROBE) begin
         enter   = 1'b1;
         state_d = IDLE;
         if (bad_now) begin
            err_hit  = 1'b1;
            err_kind = ERR_SAMPLE;
         end else begin
            pump_w_d     = pump_h_q;
            mw1_w_d      = mw1_h_q;
            free_w_d     = free_h_q;
            mw2_w_d      = mw2_h_q;
            probe_w_d    = dur_q;
            meas_valid_d = 1'b1;
            good_d       = good_q + 1'b1;
         end
      end else if (state_q != IDLE && dur_q == CNT_MAX) begin
         enter    = 1'b1;
         state_d  = IDLE;
         err_hit  = 1'b1;
         err_kind = ERR_TIMEOUT;
      end

      if (enter) begin
         dur_d = W'(1);
         bad_d = 1'b0;
      end

      // A new error beats a simultaneous clear; otherwise the first code is kept.
      if (err_hit) begin
         seq_error_d = 1'b1;
         if (!seq_error_q || clear_error) code_d = err_kind;
      end else if (clear_error) begin
         seq_error_d = 1'b0;
         code_d      = ERR_NONE;
      end
   end

   always_ff @(posedge clk_2M5) begin
      if (reset) begin
         state_q        <= IDLE;
         dur_q          <= '0;
         period_q       <= '0;
         seen_q         <= 1'b0;
         bad_q          <= 1'b0;
         pump_h_q       <= '0;
         mw1_h_q        <= '0;
         free_h_q       <= '0;
         mw2_h_q        <= '0;
         pump_w_q       <= '0;
         mw1_w_q        <= '0;
         free_w_q       <= '0;
         mw2_w_q        <= '0;
         probe_w_q      <= '0;
         meas_valid_q   <= 1'b0;
         good_q         <= '0;
         cycle_period_q <= '0;
         period_valid_q <= 1'b0;
         seq_error_q    <= 1'b0;
         code_q         <= ERR_NONE;
      end else begin
         state_q        <= state_d;
         dur_q          <= dur_d;
         period_q       <= period_d;
         seen_q         <= seen_d;
         bad_q          <= bad_d;
         pump_h_q       <= pump_h_d;
         mw1_h_q        <= mw1_h_d;
         free_h_q       <= free_h_d;
         mw2_h_q        <= mw2_h_d;
         pump_w_q       <= pump_w_d;
         mw1_w_q        <= mw1_w_d;
         free_w_q       <= free_w_d;
         mw2_w_q        <= mw2_w_d;
         probe_w_q      <= probe_w_d;
         meas_valid_q   <= meas_valid_d;
         good_q         <= good_d;
         cycle_period_q <= cycle_period_d;
         period_valid_q <= period_valid_d;
         seq_error_q    <= seq_error_d;
         code_q         <= code_d;
      end
   end

   assign pump_width   = pump_w_q;
   assign mw1_width    = mw1_w_q;
   assign free_precess = free_w_q;
   assign mw2_width    = mw2_w_q;
   assign probe_width  = probe_w_q;
   assign meas_valid   = meas_valid_q;
   assign cycle_period = cycle_period_q;
   assign period_valid = period_valid_q;
   assign good_cycles  = good_q;
   assign seq_error    = seq_error_q;
   assign error_code   = code_q;

endmodule

// File: tb/tb_pop_cycle_monitor.sv
// Bench for pop_cycle_monitor: a timestamp-based model of the pulse sequence, checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pop_cycle_monitor;

   localparam int W    = 16;
   localparam int SYNC = 2;
   localparam int MAXV = (1 << W) - 1;
   localparam int PH_IDLE = 0, PH_PUMP = 1, PH_GAP = 2, PH_MW1 = 3;
   localparam int PH_FREE = 4, PH_MW2 = 5, PH_WAITP = 6, PH_PROBE = 7;

   logic         clk_2M5 = 1'b0;
   logic         reset, pump, probe, MW, sample, clear_error;
   logic [W-1:0] pump_width, mw1_width, free_precess, mw2_width, probe_width;
   logic [W-1:0] cycle_period, good_cycles;
   logic         meas_valid, period_valid, seq_error;
   logic [1:0]   error_code;

   pop_cycle_monitor #(.W(W), .SYNC_STAGES(SYNC)) dut (
      .clk_2M5      (clk_2M5),
      .reset        (reset),
      .pump         (pump),
      .probe        (probe),
      .MW           (MW),
      .sample       (sample),
      .clear_error  (clear_error),
      .pump_width   (pump_width),
      .mw1_width    (mw1_width),
      .free_precess (free_precess),
      .mw2_width    (mw2_width),
      .probe_width  (probe_width),
      .meas_valid   (meas_valid),
      .cycle_period (cycle_period),
      .period_valid (period_valid),
      .good_cycles  (good_cycles),
      .seq_error    (seq_error),
      .error_code   (error_code)
   );

   initial forever #200 clk_2M5 = ~clk_2M5;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Signals are delayed by the synchroniser depth; durations are differences of edge timestamps.
   int       m_cyc = 0, m_phase = PH_IDLE, m_entry = 0, m_last_rise = 0;
   bit       m_seen = 0, m_bad = 0, m_started = 0;
   bit [3:0] m_dly [SYNC];
   bit [2:0] m_prev = '0;
   int       h_pw = 0, h_m1 = 0, h_fr = 0, h_m2 = 0;
   int       e_pw = 0, e_m1 = 0, e_fr = 0, e_m2 = 0, e_prw = 0, e_cp = 0, e_good = 0, e_code = 0;
   bit       e_mv = 0, e_pv = 0, e_err = 0;

   task automatic m_enter(input int ph);
      m_phase = ph;
      m_entry = m_cyc;
      if (ph == PH_PROBE) m_bad = 1'b0;
   endtask

   always @(posedge clk_2M5) begin : model
      bit [3:0] s;
      bit [2:0] rs, fl;
      bit       hit;
      int       code, dur;
      if (reset) begin
         m_phase = PH_IDLE; m_seen = 0; m_bad = 0; m_prev = '0;
         h_pw = 0; h_m1 = 0; h_fr = 0; h_m2 = 0;
         e_pw = 0; e_m1 = 0; e_fr = 0; e_m2 = 0; e_prw = 0; e_cp = 0; e_good = 0; e_code = 0;
         e_mv = 0; e_pv = 0; e_err = 0;
         for (int i = 0; i < SYNC; i++) m_dly[i] = '0;
      end else begin
         s    = m_dly[SYNC-1];
         rs   = s[2:0] & ~m_prev;
         fl   = ~s[2:0] & m_prev;
         dur  = m_cyc - m_entry;
         hit  = 0;
         code = 0;
         e_mv = 0;
         e_pv = 0;
         if (m_phase == PH_PROBE && !s[3]) m_bad = 1;
         if (rs[0]) begin
            if (m_seen && (m_cyc - m_last_rise) < MAXV) begin
               e_cp = m_cyc - m_last_rise;
               e_pv = 1;
            end
            m_last_rise = m_cyc;
            m_seen      = 1;
            if (m_phase != PH_IDLE) begin hit = 1; code = 1; end
            m_enter(PH_PUMP);
         end else if (fl[0] && m_phase == PH_PUMP) begin
            h_pw = dur; m_enter(PH_GAP);
         end else if (rs[1]) begin
            if (m_phase == PH_GAP) m_enter(PH_MW1);
            else if (m_phase == PH_FREE) begin h_fr = dur; m_enter(PH_MW2); end
            else begin hit = 1; code = 1; m_enter(PH_IDLE); end
         end else if (fl[1] && m_phase == PH_MW1) begin
            h_m1 = dur; m_enter(PH_FREE);
         end else if (fl[1] && m_phase == PH_MW2) begin
            h_m2 = dur; m_enter(PH_WAITP);
         end else if (rs[2]) begin
            if (m_phase == PH_WAITP) m_enter(PH_PROBE);
            else begin hit = 1; code = 1; m_enter(PH_IDLE); end
         end else if (fl[2] && m_phase == PH_PROBE) begin
            if (m_bad) begin hit = 1; code = 3; end
            else begin
               e_pw = h_pw; e_m1 = h_m1; e_fr = h_fr; e_m2 = h_m2; e_prw = dur;
               e_mv = 1; e_good = (e_good + 1) & MAXV;
            end
            m_enter(PH_IDLE);
         end else if (m_phase != PH_IDLE && dur >= MAXV) begin
            hit = 1; code = 2; m_enter(PH_IDLE);
         end
         if (hit) begin
            if (!e_err || clear_error) e_code = code;
            e_err = 1;
         end else if (clear_error) begin
            e_err = 0; e_code = 0;
         end
         m_prev = s[2:0];
         for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
         m_dly[0] = {sample, probe, MW, pump};
      end
      m_cyc++;
      m_started = 1;
   end

   logic [127:0] act_vec;
   assign act_vec = {11'd0, pump_width, mw1_width, free_precess, mw2_width, probe_width,
                     cycle_period, good_cycles, meas_valid, period_valid, seq_error, error_code};

   function automatic logic [127:0] exp_vec();
      return {11'd0, W'(e_pw), W'(e_m1), W'(e_fr), W'(e_m2), W'(e_prw),
              W'(e_cp), W'(e_good), e_mv, e_pv, e_err, 2'(e_code)};
   endfunction

   int mv_cnt = 0, pv_cnt = 0;
   always @(negedge clk_2M5) begin
      if (m_started) check("cycle_outputs", act_vec, exp_vec());
      if (meas_valid === 1'b1) mv_cnt++;
      if (period_valid === 1'b1) pv_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_2M5);
   endtask

   task automatic pulse_clear();
      clear_error = 1'b1;
      tick(1);
      clear_error = 1'b0;
   endtask

   // One 1000-cycle POP cycle: pump, gap 10, MW 20, free 200, MW 20, gap 5, probe, idle.
   task automatic run_cycle(input int pump_len, input int probe_len, input bit do_mw2,
                            input bit do_probe, input int drop_at);
      pump = 1'b1; tick(pump_len);
      pump = 1'b0; tick(10);
      MW = 1'b1; tick(20);
      MW = 1'b0; tick(200);
      if (do_mw2) begin MW = 1'b1; tick(20); MW = 1'b0; end
      else tick(20);
      sample = 1'b1; tick(5);
      if (do_probe) begin
         probe = 1'b1;
         for (int i = 0; i < probe_len; i++) begin
            sample = (i == drop_at) ? 1'b0 : 1'b1;
            tick(1);
         end
         probe = 1'b0; sample = 1'b1;
      end else tick(probe_len);
      tick(5);
      sample = 1'b0;
      tick(1000 - (pump_len + 10 + 20 + 200 + 20 + 5 + probe_len + 5));
   endtask

   initial begin
      #48000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int mv0, pv0;
      reset = 1'b1; pump = 1'b0; probe = 1'b0; MW = 1'b0; sample = 1'b0; clear_error = 1'b0;
      tick(5);
      check("reset_good", 128'(good_cycles), 128'(0));
      check("reset_seq_error", 128'(seq_error), 128'(0));
      check("reset_code", 128'(error_code), 128'(0));
      check("reset_pump_width", 128'(pump_width), 128'(0));
      reset = 1'b0;
      tick(3);

      // Nominal cycles.
      mv0 = mv_cnt; pv0 = pv_cnt;
      run_cycle(100, 50, 1, 1, -1);
      check("c1_pump_width", 128'(pump_width), 128'(100));
      check("c1_mw1_width", 128'(mw1_width), 128'(20));
      check("c1_free", 128'(free_precess), 128'(200));
      check("c1_mw2_width", 128'(mw2_width), 128'(20));
      check("c1_probe_width", 128'(probe_width), 128'(50));
      check("c1_good", 128'(good_cycles), 128'(1));
      check("c1_no_period", 128'(cycle_period), 128'(0));
      run_cycle(100, 50, 1, 1, -1);
      run_cycle(100, 50, 1, 1, -1);
      check("c3_period", 128'(cycle_period), 128'(1000));
      check("c3_good", 128'(good_cycles), 128'(3));
      check("c3_meas_pulses", 128'(mv_cnt - mv0), 128'(3));
      check("c3_period_pulses", 128'(pv_cnt - pv0), 128'(2));

      // Second MW and probe omitted: next pump rise lands in FREE.
      run_cycle(100, 50, 0, 0, -1);
      run_cycle(100, 50, 1, 1, -1);
      check("skipmw_seq_error", 128'(seq_error), 128'(1));
      check("skipmw_code", 128'(error_code), 128'(1));
      check("skipmw_good", 128'(good_cycles), 128'(4));
      pulse_clear();
      check("clear_code", 128'(error_code), 128'(0));
      check("clear_seq_error", 128'(seq_error), 128'(0));

      // Probe omitted: next pump rise lands in WAITP.
      run_cycle(100, 50, 1, 0, -1);
      run_cycle(100, 50, 1, 1, -1);
      check("waitp_code", 128'(error_code), 128'(1));
      check("waitp_good", 128'(good_cycles), 128'(5));
      pulse_clear();

      // Sample drops for one cycle during probe; distinct widths must not appear.
      run_cycle(90, 60, 1, 1, 20);
      check("drop_code", 128'(error_code), 128'(3));
      check("drop_pump_width", 128'(pump_width), 128'(100));
      check("drop_probe_width", 128'(probe_width), 128'(50));
      check("drop_good", 128'(good_cycles), 128'(5));
      pulse_clear();

      // Pump and MW rise together in GAP: pump wins and restarts the cycle.
      pump = 1'b1; tick(100);
      pump = 1'b0; tick(10);
      pump = 1'b1; MW = 1'b1; tick(30);
      check("coinc_code", 128'(error_code), 128'(1));
      pump = 1'b0; tick(10);
      MW = 1'b0; tick(10);
      MW = 1'b1; tick(20); MW = 1'b0; tick(200);
      MW = 1'b1; tick(20); MW = 1'b0;
      sample = 1'b1; tick(5);
      probe = 1'b1; tick(50); probe = 1'b0; tick(5);
      sample = 1'b0; tick(400);
      check("coinc_pump_width", 128'(pump_width), 128'(30));
      check("coinc_period", 128'(cycle_period), 128'(110));
      check("coinc_good", 128'(good_cycles), 128'(6));
      pulse_clear();

      // MW stuck high past the duration counter range.
      mv0 = mv_cnt;
      pump = 1'b1; tick(100);
      pump = 1'b0; tick(10);
      MW = 1'b1; tick(66000);
      MW = 1'b0; tick(100);
      check("timeout_code", 128'(error_code), 128'(2));
      check("timeout_no_meas", 128'(mv_cnt - mv0), 128'(0));
      check("timeout_good", 128'(good_cycles), 128'(6));
      pulse_clear();
      pv0 = pv_cnt;
      run_cycle(100, 50, 1, 1, -1);
      check("post_timeout_seq_error", 128'(seq_error), 128'(0));
      check("post_timeout_good", 128'(good_cycles), 128'(7));
      check("post_timeout_no_period", 128'(pv_cnt - pv0), 128'(0));

      // Reset while in FREE, then good cycles.
      pump = 1'b1; tick(100);
      pump = 1'b0; tick(10);
      MW = 1'b1; tick(20);
      MW = 1'b0; tick(50);
      reset = 1'b1; tick(3);
      reset = 1'b0;
      check("rst_free_good", 128'(good_cycles), 128'(0));
      check("rst_free_pump_width", 128'(pump_width), 128'(0));
      check("rst_free_period", 128'(cycle_period), 128'(0));
      mv0 = mv_cnt; pv0 = pv_cnt;
      run_cycle(100, 50, 1, 1, -1);
      check("rst_c1_meas_pulses", 128'(mv_cnt - mv0), 128'(1));
      check("rst_c1_no_period", 128'(pv_cnt - pv0), 128'(0));
      check("rst_c1_good", 128'(good_cycles), 128'(1));
      check("rst_c1_pump_width", 128'(pump_width), 128'(100));
      run_cycle(100, 50, 1, 1, -1);
      check("rst_c2_period_pulses", 128'(pv_cnt - pv0), 128'(1));
      check("rst_c2_period", 128'(cycle_period), 128'(1000));
      check("rst_c2_good", 128'(good_cycles), 128'(2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
